// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM between the CPU core and one external
// requester (video fetch, UART DMA, ...). The CPU wins by default. A starvation
// counter switches the block into external priority after STARVE_MAX denied
// cycles. The external port then gets a burst of up to BURST_MAX grants while
// the core is held via its stall input.
//
// Optional feature macro: DMEM_ARB_STATS_EN
//   defined   -> saturating 16-bit counters of stall cycles and external grants
//   undefined -> stat outputs tied to 0, no counter flops
//
// Ports
//   clk, resetN          clock, asynchronous active-low reset
//   cpu_read_m           CPU read request
//   cpu_write_m          CPU write request (core gates it with cpu_stall)
//   cpu_data_addr        CPU address
//   cpu_out_m            CPU write data
//   cpu_in_m             CPU read data (= ram_rdata, same cycle)
//   cpu_stall            drives the core's stall input
//   ext_req/ext_gnt      external request / access performed this cycle
//   ext_we               external write (1) or read (0)
//   ext_addr, ext_wdata  external address / write data
//   ext_rvalid           one-cycle pulse, ext_rdata valid
//   ext_rdata            registered external read data
//   ram_addr/we/wdata    RAM macro controls
//   ram_rdata            RAM read data, combinational read
//   stat_stall_cycles    stall cycle count (stats build only)
//   stat_ext_grants      external grant count (stats build only)
//
// External handshake: ext_req is raised with ext_we/ext_addr/ext_wdata stable
// and held until ext_gnt is seen high in the same cycle. The access completes
// in that cycle: a write is committed at the clock edge ending it, a read
// returns ext_rdata with ext_rvalid exactly one cycle later. There is no
// backpressure on ext_rvalid.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cpu_read_m,
  input  logic              cpu_write_m,
  input  logic [ADDR_W-1:0] cpu_data_addr,
  input  logic [DATA_W-1:0] cpu_out_m,
  output logic [DATA_W-1:0] cpu_in_m,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       stat_stall_cycles,
  output logic [15:0]       stat_ext_grants
);

  localparam int WAIT_W  = $clog2(STARVE_MAX + 1);
  localparam int BURST_W = $clog2(BURST_MAX + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_MAX - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  typedef enum logic {
    CPU_PRI = 1'b0,
    EXT_PRI = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= CPU_PRI;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and arbitration outputs.
  // cpu_stall is built from state and ext_req only: the core feeds stall back
  // into write_m, so any cpu_* term here would close a combinational loop.
  // During reset state_q is already CPU_PRI, so the CPU_PRI equations apply.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    ext_gnt     = 1'b0;
    cpu_stall   = 1'b0;

    case (state_q)
      CPU_PRI: begin
        ext_gnt     = ext_req & ~cpu_read_m & ~cpu_write_m;
        burst_cnt_d = '0;
        if (ext_req && !ext_gnt) begin
          // Denied cycle: the STARVE_MAX-th consecutive denial flips priority.
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = EXT_PRI;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Granted or not requesting: a grant on the limit cycle simply wins.
          wait_cnt_d = '0;
        end
      end

      EXT_PRI: begin
        ext_gnt    = ext_req;
        cpu_stall  = ext_req;
        wait_cnt_d = '0;
        if (!ext_req) begin
          // Requester went away mid-burst: hand the RAM back immediately.
          state_d     = CPU_PRI;
          burst_cnt_d = '0;
        end else if (burst_cnt_q == BURST_LAST) begin
          state_d     = CPU_PRI;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end

      default: begin
        state_d     = CPU_PRI;
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM mux. The CPU path is the default owner; cpu_in_m is always the raw RAM
  // output, the core only looks at it when it is not stalled.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (ext_gnt) begin
      ram_addr  = ext_addr;
      ram_we    = ext_we;
      ram_wdata = ext_wdata;
    end else begin
      ram_addr  = cpu_data_addr;
      ram_we    = cpu_write_m;
      ram_wdata = cpu_out_m;
    end
  end

  assign cpu_in_m = ram_rdata;

  // ---------------------------------------------------------------------------
  // External read return path: capture on the grant cycle, pulse next cycle.
  // ext_rdata holds its last value between reads.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt && !ext_we) begin
        ext_rdata <= ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] ext_grants_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stall_cycles_q <= '0;
      ext_grants_q   <= '0;
    end else begin
      if (cpu_stall && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      if (ext_gnt && (ext_grants_q != 16'hFFFF)) begin
        ext_grants_q <= ext_grants_q + 16'd1;
      end
    end
  end

  assign stat_stall_cycles = stall_cycles_q;
  assign stat_ext_grants   = ext_grants_q;
`else
  assign stat_stall_cycles = 16'd0;
  assign stat_ext_grants   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. Provides a RAM model with combinational read, runs
// table-driven directed scenarios and a randomized phase. Every cycle is also
// checked against a reference model that tracks "denied streak" and "grants
// used in this episode" as plain integers, an expected-memory image, and an
// expected read-data queue.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 8;
  localparam int BURST_MAX  = 4;
  localparam int MEM_DEPTH  = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic              cpu_read_m, cpu_write_m;
  logic [ADDR_W-1:0] cpu_data_addr;
  logic [DATA_W-1:0] cpu_out_m, cpu_in_m;
  logic              cpu_stall;
  logic              ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [15:0]       stat_stall_cycles, stat_ext_grants;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .resetN(resetN),
    .cpu_read_m(cpu_read_m), .cpu_write_m(cpu_write_m),
    .cpu_data_addr(cpu_data_addr), .cpu_out_m(cpu_out_m),
    .cpu_in_m(cpu_in_m), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .stat_stall_cycles(stat_stall_cycles), .stat_ext_grants(stat_ext_grants)
  );

  // RAM macro model: combinational read, write at the clock edge.
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];            // expected external read data
  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];  // expected RAM contents
  bit                m_ext_pri;            // external has priority
  int                m_streak;             // consecutive denied cycles
  int                m_burst;              // grants used in current episode
  bit                m_rvalid;
  logic [DATA_W-1:0] m_last_rdata;
  int                m_stall_cnt, m_gnt_cnt;

  task automatic model_reset();
    m_ext_pri    = 1'b0;
    m_streak     = 0;
    m_burst      = 0;
    m_rvalid     = 1'b0;
    m_last_rdata = '0;
    m_stall_cnt  = 0;
    m_gnt_cnt    = 0;
    exp_q.delete();
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", n, act, exp);
    end
  endtask

  task automatic chk16(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector records
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              gate_wr;     // emulate the core gating write_m by stall
    logic              use_exp;
    logic              exp_gnt;
    logic              exp_stall;
    logic              exp_rvalid;
    logic              chk_rdata;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];
  logic prev_rd_gnt = 1'b0;

  function automatic vec_t mk(input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                              input logic rq, input logic we,
                              input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed);
    vec_t v;
    v.cpu_rd = rd;  v.cpu_wr = wr;  v.cpu_addr = ca;  v.cpu_wdata = cd;
    v.ext_req = rq; v.ext_we = we;  v.ext_addr = ea;  v.ext_wdata = ed;
    v.gate_wr = 1'b0; v.use_exp = 1'b0;
    v.exp_gnt = 1'b0; v.exp_stall = 1'b0; v.exp_rvalid = 1'b0;
    v.chk_rdata = 1'b0; v.exp_rdata = '0;
    return v;
  endfunction

  // Appends a row with expected grant/stall; ext_rvalid is expected whenever
  // the previous row was a granted external read.
  task automatic add_row(input vec_t v, input logic g, input logic s);
    vec_t r;
    r = v;
    r.use_exp    = 1'b1;
    r.exp_gnt    = g;
    r.exp_stall  = s;
    r.exp_rvalid = prev_rd_gnt;
    prev_rd_gnt  = g & ~v.ext_we;
    tbl.push_back(r);
  endtask

  // ---------------------------------------------------------------------------
  // Driver + per-cycle check + reference model step
  // ---------------------------------------------------------------------------
  task automatic run_cycle(input vec_t v, input string name, output logic granted);
    logic              e_gnt, e_stall, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rd;
    @(negedge clk);
    cpu_read_m    = v.cpu_rd;
    cpu_write_m   = v.cpu_wr;
    cpu_data_addr = v.cpu_addr;
    cpu_out_m     = v.cpu_wdata;
    ext_req       = v.ext_req;
    ext_we        = v.ext_we;
    ext_addr      = v.ext_addr;
    ext_wdata     = v.ext_wdata;
    if (v.gate_wr) begin
      #1;
      cpu_write_m = v.cpu_wr & ~cpu_stall;
    end
    #1;

    // Expected arbitration from the priority rules.
    if (m_ext_pri) begin
      e_gnt   = ext_req;
      e_stall = ext_req;
    end else begin
      e_gnt   = ext_req & ~cpu_read_m & ~cpu_write_m;
      e_stall = 1'b0;
    end
    e_addr  = e_gnt ? ext_addr  : cpu_data_addr;
    e_we    = e_gnt ? ext_we    : cpu_write_m;
    e_wdata = e_gnt ? ext_wdata : cpu_out_m;
    e_rd    = ref_mem[e_addr];

    chk1({name, " ext_gnt"}, ext_gnt, e_gnt);
    chk1({name, " cpu_stall"}, cpu_stall, e_stall);
    chk1({name, " ram_we"}, ram_we, e_we);
    chk16({name, " ram_addr"}, 16'(ram_addr), 16'(e_addr));
    chk16({name, " ram_wdata"}, ram_wdata, e_wdata);
    chk16({name, " cpu_in_m"}, cpu_in_m, e_rd);
    chk1({name, " ext_rvalid"}, ext_rvalid, m_rvalid);
    if (m_rvalid && (exp_q.size() > 0)) m_last_rdata = exp_q.pop_front();
    chk16({name, " ext_rdata"}, ext_rdata, m_last_rdata);
`ifdef DMEM_ARB_STATS_EN
    chk16({name, " stat_stall"}, stat_stall_cycles, 16'(m_stall_cnt));
    chk16({name, " stat_gnt"}, stat_ext_grants, 16'(m_gnt_cnt));
`else
    chk16({name, " stat_stall"}, stat_stall_cycles, 16'd0);
    chk16({name, " stat_gnt"}, stat_ext_grants, 16'd0);
`endif
    if (v.use_exp) begin
      chk1({name, " tbl gnt"}, ext_gnt, v.exp_gnt);
      chk1({name, " tbl stall"}, cpu_stall, v.exp_stall);
      chk1({name, " tbl rvalid"}, ext_rvalid, v.exp_rvalid);
      if (v.chk_rdata) chk16({name, " tbl rdata"}, ext_rdata, v.exp_rdata);
    end

    // Advance the model to the state after the coming clock edge.
    if (e_gnt && !ext_we) exp_q.push_back(ref_mem[ext_addr]);
    m_rvalid = e_gnt & ~ext_we;
    if (e_we) ref_mem[e_addr] = e_wdata;
    if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (e_gnt && m_gnt_cnt < 65535) m_gnt_cnt++;
    if (!m_ext_pri) begin
      if (ext_req && !e_gnt) begin
        m_streak++;
        if (m_streak == STARVE_MAX) begin
          m_ext_pri = 1'b1;
          m_streak  = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (!ext_req) begin
        m_ext_pri = 1'b0;
        m_burst   = 0;
      end else begin
        m_burst++;
        if (m_burst == BURST_MAX) begin
          m_ext_pri = 1'b0;
          m_burst   = 0;
        end
      end
    end
    granted = e_gnt;
  endtask

  task automatic run_table(input string name);
    logic g;
    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i], $sformatf("%s[%0d]", name, i), g);
    end
    tbl.delete();
  endtask

  task automatic set_idle();
    cpu_read_m = 1'b0; cpu_write_m = 1'b0; cpu_data_addr = '0; cpu_out_m = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    resetN = 1'b0;
    set_idle();
    #1;
    chk1({name, " rst stall"}, cpu_stall, 1'b0);
    chk1({name, " rst gnt"}, ext_gnt, 1'b0);
    chk1({name, " rst rvalid"}, ext_rvalid, 1'b0);
    chk16({name, " rst rdata"}, ext_rdata, 16'h0000);
    chk16({name, " rst stat_stall"}, stat_stall_cycles, 16'h0000);
    chk16({name, " rst stat_gnt"}, stat_ext_grants, 16'h0000);
    model_reset();
    prev_rd_gnt = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t v;
    logic g;
    bit   pend;
    int   busy_pct;

    set_idle();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem[i]     <= '0;
      ref_mem[i]  = '0;
    end
    mem[5]     <= 16'h1234;
    ref_mem[5]  = 16'h1234;

    // 1: external alone, CPU idle -> same-cycle grant, read data next cycle.
    do_reset("s1");
    add_row(mk(0, 0, 15'd0, 16'h0, 1, 0, 15'd5, 16'h0), 1'b1, 1'b0);
    v = mk(0, 0, 15'd0, 16'h0, 0, 0, 15'd0, 16'h0);
    v.chk_rdata = 1'b1;
    v.exp_rdata = 16'h1234;
    add_row(v, 1'b0, 1'b0);
    run_table("s1");

    // 2: CPU reads every cycle, ext_req held: 8 denials, 4 stalled grants, repeat.
    do_reset("s2");
    for (int i = 0; i < 12; i++) begin
      add_row(mk(1, 0, 15'(i), 16'h0, 1, 0, 15'd5, 16'h0), (i >= 8), (i >= 8));
    end
    run_table("s2a");
`ifdef DMEM_ARB_STATS_EN
    @(posedge clk);
    #1;
    chk16("s2 stat_stall_cycles", stat_stall_cycles, 16'd4);
    chk16("s2 stat_ext_grants", stat_ext_grants, 16'd4);
`endif
    for (int i = 0; i < 12; i++) begin
      add_row(mk(1, 0, 15'(i + 3), 16'h0, 1, 0, 15'(i), 16'h0), (i >= 8), (i >= 8));
    end
    run_table("s2b");

    // 3: ext_req drops after two burst grants; starvation count restarts at 0.
    do_reset("s3");
    for (int i = 0; i < 8; i++) add_row(mk(1, 0, 15'd1, 16'h0, 1, 0, 15'd5, 16'h0), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add_row(mk(1, 0, 15'd1, 16'h0, 1, 0, 15'd5, 16'h0), 1'b1, 1'b1);
    add_row(mk(1, 0, 15'd1, 16'h0, 0, 0, 15'd5, 16'h0), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add_row(mk(1, 0, 15'd2, 16'h0, 1, 0, 15'd5, 16'h0), 1'b0, 1'b0);
    add_row(mk(1, 0, 15'd2, 16'h0, 1, 0, 15'd5, 16'h0), 1'b1, 1'b1);
    run_table("s3");

    // 4: simultaneous writes to address 3 while external has priority.
    do_reset("s4");
    for (int i = 0; i < 8; i++) add_row(mk(1, 0, 15'd9, 16'h0, 1, 1, 15'd3, 16'hBBBB), 1'b0, 1'b0);
    run_table("s4a");
    v = mk(0, 1, 15'd3, 16'hAAAA, 1, 1, 15'd3, 16'hBBBB);
    v.gate_wr = 1'b1;
    add_row(v, 1'b1, 1'b1);
    run_table("s4b");
    @(posedge clk);
    #1;
    chk16("s4 ram3 after ext write", mem[3], 16'hBBBB);
    v = mk(0, 1, 15'd3, 16'hAAAA, 0, 0, 15'd0, 16'h0);
    v.gate_wr = 1'b1;
    add_row(v, 1'b0, 1'b0);
    run_table("s4c");
    @(posedge clk);
    #1;
    chk16("s4 ram3 after cpu write", mem[3], 16'hAAAA);

    // 5: reset pulsed low mid-burst with a read return pending.
    do_reset("s5");
    for (int i = 0; i < 8; i++) add_row(mk(1, 0, 15'd0, 16'h0, 1, 0, 15'd5, 16'h0), 1'b0, 1'b0);
    add_row(mk(1, 0, 15'd0, 16'h0, 1, 0, 15'd5, 16'h0), 1'b1, 1'b1);
    run_table("s5");
    @(negedge clk);
    cpu_read_m = 1'b0;
    cpu_write_m = 1'b0;
    ext_req = 1'b1;
    #1;
    chk1("s5 pre stall", cpu_stall, 1'b1);
    chk1("s5 pre rvalid", ext_rvalid, 1'b1);
    resetN = 1'b0;
    #1;
    chk1("s5 rst stall", cpu_stall, 1'b0);
    chk1("s5 rst gnt cpu idle", ext_gnt, 1'b1);
    chk1("s5 rst rvalid dropped", ext_rvalid, 1'b0);
    chk16("s5 rst rdata", ext_rdata, 16'h0000);
    do_reset("s5b");

    // 6: wait limit reached on the cycle the CPU goes idle -> grant, no switch.
    for (int i = 0; i < 7; i++) add_row(mk(1, 0, 15'd4, 16'h0, 1, 0, 15'd6, 16'h0), 1'b0, 1'b0);
    add_row(mk(0, 0, 15'd4, 16'h0, 1, 0, 15'd6, 16'h0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add_row(mk(1, 0, 15'd4, 16'h0, 1, 0, 15'd6, 16'h0), 1'b0, 1'b0);
    run_table("s6");

    // 7: randomized traffic at several CPU load levels against the model.
    do_reset("rnd");
    pend = 1'b0;
    v = mk(0, 0, 15'd0, 16'h0, 0, 0, 15'd0, 16'h0);
    for (int ph = 0; ph < 4; ph++) begin
      busy_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 100;
      for (int c = 0; c < 600; c++) begin
        if (!pend && ($urandom_range(0, 99) < 60)) begin
          pend        = 1'b1;
          v.ext_we    = 1'($urandom_range(0, 1));
          v.ext_addr  = 15'($urandom_range(0, 15));
          v.ext_wdata = 16'($urandom);
        end
        v.ext_req   = pend;
        v.cpu_rd    = 1'b0;
        v.cpu_wr    = 1'b0;
        if ($urandom_range(0, 99) < busy_pct) begin
          if ($urandom_range(0, 1) == 0) v.cpu_rd = 1'b1;
          else                           v.cpu_wr = 1'b1;
        end
        v.cpu_addr  = 15'($urandom_range(0, 15));
        v.cpu_wdata = 16'($urandom);
        v.gate_wr   = 1'b1;
        run_cycle(v, $sformatf("rnd%0d.%0d", ph, c), g);
        if (g) pend = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between the CPU core and one external requester, such as a video-fetch or UART DMA engine. The CPU has priority by default. A starvation counter gives the external port a bounded burst of exclusive access, and the CPU is held with its `stall` input during that burst. The block sits between the core's `out_m`/`in_m`/`data_addr`/`read_m`/`write_m` and the RAM macro.

## Interface
- `ADDR_W`, 15: data address width.
- `DATA_W`, 16: data word width.
- `STARVE_MAX`, 8: consecutive denied external cycles before the block switches to external priority. Must be ≥1.
- `BURST_MAX`, 4: maximum external grants per external-priority episode. Must be ≥1.

Ports:
- `clk`  in  1  clock.
- `resetN`  in  1  asynchronous active-low reset.
- `cpu_read_m`  in  1  CPU read request.
- `cpu_write_m`  in  1  CPU write request.
- `cpu_data_addr`  in  ADDR_W  CPU address.
- `cpu_out_m`  in  DATA_W  CPU write data.
- `cpu_in_m`  out  DATA_W  CPU read data.
- `cpu_stall`  out  1  drives the core's `stall` input.
- `ext_req`  in  1  external access request, held until granted.
- `ext_we`  in  1  1 = write, 0 = read.
- `ext_addr`  in  ADDR_W  external address.
- `ext_wdata`  in  DATA_W  external write data.
- `ext_gnt`  out  1  access performed this cycle.
- `ext_rvalid`  out  1  one-cycle pulse; `ext_rdata` is valid.
- `ext_rdata`  out  DATA_W  registered read data.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, combinational (same-cycle) read.
- `stat_stall_cycles`  out  16  see Configuration.
- `stat_ext_grants`  out  16  see Configuration.

## Operation
- There are two FSM states. The reset state is `CPU_PRI`; the other state is `EXT_PRI`.
- Signals in `CPU_PRI`:
  - `cpu_stall`=0.
  - `ext_gnt = ext_req & ~cpu_read_m & ~cpu_write_m`.
- Signals in `EXT_PRI`:
  - `ext_gnt = ext_req`.
  - `cpu_stall = ext_req`. The CPU is stalled regardless of whether it is accessing memory.
  - `cpu_stall` must never depend on the `cpu_*` inputs, because the core gates `write_m` with `stall` and a dependency would create a combinational loop.
- RAM mux:
  - `ram_addr`/`ram_we`/`ram_wdata` come from the `ext_*` inputs when `ext_gnt`=1, otherwise from `cpu_data_addr`/`cpu_write_m`/`cpu_out_m`.
  - `cpu_in_m = ram_rdata` always.
- Wait counter `wait_cnt`, width clog2(STARVE_MAX+1):
  - Increments in `CPU_PRI` when `ext_req & ~ext_gnt`.
  - Clears when `ext_gnt` or `~ext_req`.
- Transition `CPU_PRI` → `EXT_PRI`: on a denied cycle with `wait_cnt == STARVE_MAX-1`. `wait_cnt` clears on the transition.
- Burst counter `burst_cnt`: increments on each grant in `EXT_PRI`.
- Transitions `EXT_PRI` → `CPU_PRI`:
  - On a grant with `burst_cnt == BURST_MAX-1`.
  - Or when `ext_req`=0, in which case there is no grant and no stall that cycle.
  - `burst_cnt` clears on either transition.
- External read: on a cycle with `ext_gnt & ~ext_we`, `ext_rdata <= ram_rdata` and `ext_rvalid <= 1` next cycle. `ext_rvalid` is otherwise 0.
- External write: commits in the `ext_gnt` cycle. There is no further acknowledge.

## Timing
- Reset values (async): state `CPU_PRI`, `wait_cnt`=0, `burst_cnt`=0, `ext_rvalid`=0, `ext_rdata`=0, stats=0.
- While `resetN` is low, the combinational outputs follow the `CPU_PRI` equations.
- CPU access latency is 0 cycles (same-cycle RAM read).
- External grant latency:
  - 0 cycles when the CPU is idle.
  - Worst case STARVE_MAX cycles of denial, then granted on the following cycle.
- External read data: `ext_rvalid` asserts 1 cycle after the grant.
- Back-to-back external reads produce back-to-back `ext_rvalid` pulses.
- Boundary cases:
  - If `wait_cnt` reaches its limit on the same cycle the CPU goes idle, the grant wins: `wait_cnt` clears and there is no state change.
  - Reset asserted mid-burst: the FSM returns to `CPU_PRI` immediately, and a pending `ext_rvalid` is dropped.
- After an `EXT_PRI` episode the CPU is guaranteed at least STARVE_MAX cycles of priority before the next episode.

## Configuration
- With `DMEM_ARB_STATS_EN` defined:
  - `stat_stall_cycles` counts cycles with `cpu_stall`=1.
  - `stat_ext_grants` counts `ext_gnt` cycles.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Without `DMEM_ARB_STATS_EN`, both stat outputs are tied to 0 and no counter flops exist.

## Test plan
- External requester alone, CPU idle: `ext_req`=1, `ext_we`=0, `ext_addr`=5, RAM[5]=16'h1234. Required: `ext_gnt`=1 the same cycle; `ext_rvalid`=1 with `ext_rdata`=16'h1234 the next cycle; `cpu_stall`=0.
- CPU reading every cycle, `ext_req` held high, defaults: `ext_gnt`=0 for 8 cycles, then `cpu_stall`=1 and `ext_gnt`=1 for 4 cycles. Then `CPU_PRI` resumes and the pattern repeats.
- Mid-burst drop: `ext_req` deasserted after 2 grants in `EXT_PRI`. Required: `cpu_stall`=0 on that cycle, and the next denial restarts `wait_cnt` at 0.
- Simultaneous writes: CPU writes addr 3=16'hAAAA while external writes addr 3=16'hBBBB in `EXT_PRI`. Required: RAM[3]=16'hBBBB, the core sees stall so its `write_m`=0, and the CPU write lands on the next `CPU_PRI` cycle.
- `resetN` pulsed low during `EXT_PRI`: outputs go immediately to reset values, and `cpu_stall`=0 with the CPU idle.
- With `DMEM_ARB_STATS_EN`: after the second scenario's first episode, `stat_stall_cycles`=4 and `stat_ext_grants`=4.
